acc_readout_uart_tx: RTL and testbench
======================================

ACC_READOUT_UART_TX -- requirements
Module: acc_readout_uart_tx

Interface
REQ-001 SHALL have parameter ACC_WIDTH, default 32, accumulator word width; fixed at 32 for this block.
REQ-002 SHALL have parameter MATRIX_SIZE, default 8, systolic array dimension.
REQ-003 SHALL have parameter ACC_ADDR_WIDTH, default $clog2(MATRIX_SIZE*MATRIX_SIZE), accumulator address width.
REQ-004 SHALL have parameter CLK_PER_BIT, default 54 (50 MHz / 921600 baud), clocks per UART bit, minimum 2.
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port start  input  1  one-cycle request to dump accumulators.
REQ-008 SHALL have port base_addr  input  ACC_ADDR_WIDTH  first accumulator index, sampled with start.
REQ-009 SHALL have port count  input  ACC_ADDR_WIDTH+1  number of words to send (0..64), sampled with start.
REQ-010 SHALL have port addr_acc  output  ACC_ADDR_WIDTH  read address to systolic array.
REQ-011 SHALL have port acc_out  input  ACC_WIDTH  accumulator data, valid the cycle addr_acc is driven.
REQ-012 SHALL have port uart_tx  output  1  UART serial line, idle high.
REQ-013 SHALL have port busy  output  1  high from cycle after accepted start until done.
REQ-014 SHALL have port done  output  1  one-cycle pulse at end of dump.

Function
REQ-015 SHALL implement states IDLE, FETCH, START_BIT, DATA_BITS, STOP_BIT, DONE.
REQ-016 SHALL, in IDLE, accept start=1 by latching base_addr into address counter and count into remaining counter; go to FETCH if count!=0, else DONE.
REQ-017 SHALL ignore start while busy=1 (no re-latch, no effect on current dump).
REQ-018 SHALL, in FETCH (exactly 1 cycle, uart_tx=1), drive addr_acc=address counter and capture acc_out into a 32-bit word register at the ending edge; then enter START_BIT with byte index 0.
REQ-019 SHALL send each word as 4 bytes, little-endian: word[7:0] first, word[31:24] last.
REQ-020 SHALL frame each byte 8N1: start bit 0, 8 data bits LSB first, stop bit 1; every bit held exactly CLK_PER_BIT cycles.
REQ-021 SHALL send bytes 1..3 of a word back-to-back with no idle cycles between stop bit and next start bit.
REQ-022 SHALL, after stop bit of byte 3, increment address modulo 2^ACC_ADDR_WIDTH (63 wraps to 0), decrement remaining; go to FETCH if remaining!=0, else DONE.
REQ-023 SHALL, in DONE (1 cycle), assert done=1, busy=0 that cycle, uart_tx=1, then return to IDLE; start in DONE is ignored.
REQ-024 SHALL drive uart_tx from a register (glitch-free) and hold addr_acc stable throughout each word.
REQ-025 SHALL take exactly 1 + 40*CLK_PER_BIT cycles per word; total latency start-edge to done = N*(1+40*CLK_PER_BIT)+1 cycles for N>0, 1 cycle for N=0.

Reset
REQ-026 SHALL on rst=1 set state IDLE, uart_tx=1, busy=0, done=0, addr_acc=0, counters 0, at the next edge.
REQ-027 SHALL, on rst mid-frame, abort immediately: uart_tx high from the following cycle, no done pulse, partial byte not resumed.
REQ-028 SHALL give rst priority over start in the same cycle.

Verification (CLK_PER_BIT=4 in bench)
REQ-029 SHALL verify single word: base=5, count=1, acc[5]=0xDEADBEEF -> bytes EF,BE,AD,DE on uart_tx, each bit 4 cycles, done at cycle 162 after start edge.
REQ-030 SHALL verify wrap: base=62, count=3 -> addr_acc sequence 62,63,0; 12 bytes decoded in order; busy high throughout.
REQ-031 SHALL verify count=0 -> no start bit, done pulse next cycle, uart_tx stays 1.
REQ-032 SHALL verify start pulsed mid-dump (base=0,count=2, second start base=9) -> ignored, only addresses 0,1 sent.
REQ-033 SHALL verify rst asserted during data bit 3 of byte 1 -> uart_tx=1, busy=0 next cycle; new start then dumps correctly.
REQ-034 SHALL verify full dump base=0,count=64 -> 256 bytes, all frames valid, exactly one done pulse.

Source files
------------

// File: rtl/acc_readout_uart_tx.sv
// Streams a run of accumulator words out of the systolic array over an 8N1 UART,
// four bytes per word, least significant byte first.
module acc_readout_uart_tx #(
  parameter int ACC_WIDTH      = 32,
  parameter int MATRIX_SIZE    = 8,
  parameter int ACC_ADDR_WIDTH = $clog2(MATRIX_SIZE * MATRIX_SIZE),
  parameter int CLK_PER_BIT    = 54
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [ACC_ADDR_WIDTH-1:0] base_addr,
  input  logic [ACC_ADDR_WIDTH:0]   count,
  output logic [ACC_ADDR_WIDTH-1:0] addr_acc,
  input  logic [ACC_WIDTH-1:0]      acc_out,
  output logic                      uart_tx,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned CNT_W = (CLK_PER_BIT > 2) ? $clog2(CLK_PER_BIT) : 1;
  localparam int unsigned REM_W = ACC_ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLK_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    START_BIT,
    DATA_BITS,
    STOP_BIT,
    DONE
  } state_t;

  state_t                 state;
  logic [CNT_W-1:0]       clk_cnt;
  logic [2:0]             bit_idx;
  logic [1:0]             byte_idx;
  logic [ACC_WIDTH-1:0]   word;
  logic [7:0]             shifter;
  logic [REM_W-1:0]       remaining;
  logic                   bit_end;

  // Last clock of the current UART bit period.
  assign bit_end = (clk_cnt == BIT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      clk_cnt   <= '0;
      bit_idx   <= '0;
      byte_idx  <= '0;
      word      <= '0;
      shifter   <= '0;
      remaining <= '0;
      addr_acc  <= '0;
      uart_tx   <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          uart_tx <= 1'b1;
          busy    <= 1'b0;
          if (start) begin
            addr_acc  <= base_addr;
            remaining <= count;
            if (count != '0) begin
              state <= FETCH;
              busy  <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end

        // addr_acc has been stable for this whole cycle; acc_out is valid now.
        FETCH: begin
          word     <= acc_out;
          shifter  <= acc_out[7:0];
          byte_idx <= '0;
          clk_cnt  <= '0;
          uart_tx  <= 1'b0;
          state    <= START_BIT;
        end

        START_BIT: begin
          clk_cnt <= bit_end ? '0 : clk_cnt + CNT_W'(1);
          if (bit_end) begin
            uart_tx <= shifter[0];
            shifter <= {1'b0, shifter[7:1]};
            bit_idx <= '0;
            state   <= DATA_BITS;
          end
        end

        DATA_BITS: begin
          clk_cnt <= bit_end ? '0 : clk_cnt + CNT_W'(1);
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
              uart_tx <= 1'b1;
              state   <= STOP_BIT;
            end else begin
              uart_tx <= shifter[0];
              shifter <= {1'b0, shifter[7:1]};
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end

        // Stop bit either chains straight into the next byte's start bit or closes the word.
        STOP_BIT: begin
          clk_cnt <= bit_end ? '0 : clk_cnt + CNT_W'(1);
          if (bit_end) begin
            if (byte_idx == 2'd3) begin
              addr_acc  <= addr_acc + ACC_ADDR_WIDTH'(1);
              remaining <= remaining - REM_W'(1);
              if (remaining == REM_W'(1)) begin
                state <= DONE;
                done  <= 1'b1;
                busy  <= 1'b0;
              end else begin
                state <= FETCH;
              end
            end else begin
              byte_idx <= byte_idx + 2'd1;
              word     <= word >> 8;
              shifter  <= word[15:8];
              uart_tx  <= 1'b0;
              state    <= START_BIT;
            end
          end
        end

        DONE: begin
          uart_tx <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end

        default: begin
          uart_tx <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_acc_readout_uart_tx.sv
// Scoreboard bench for acc_readout_uart_tx: a UART receiver, an address watcher and a
// done watcher pop expectations pushed by the stimulus from a simple dump model.
module tb_acc_readout_uart_tx;

  localparam int CPB    = 4;
  localparam int AW     = 6;
  localparam int FRAME  = 10 * CPB;

  logic          clk;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   count;
  logic [AW-1:0] addr_acc;
  logic [31:0]   acc_out;
  logic          uart_tx;
  logic          busy;
  logic          done;

  acc_readout_uart_tx #(
    .ACC_WIDTH(32),
    .MATRIX_SIZE(8),
    .ACC_ADDR_WIDTH(AW),
    .CLK_PER_BIT(CPB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .base_addr(base_addr),
    .count(count),
    .addr_acc(addr_acc),
    .acc_out(acc_out),
    .uart_tx(uart_tx),
    .busy(busy),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] mem [64];
  always_comb acc_out = mem[addr_acc];

  logic [7:0]    exp_bytes[$];
  logic [AW-1:0] exp_addr[$];
  int            exp_done[$];

  int total = 0;
  int bad   = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void unexpected(input string name, input logic [31:0] act);
    total++;
    bad++;
    $display("FAIL %s: got %0h expected nothing", name, act);
  endfunction

  // UART receiver: collects one full frame per falling edge and checks 8N1 framing.
  bit samp [FRAME];
  bit in_frame = 0;
  bit busy_all = 0;
  int nsamp    = 0;
  initial forever begin
    @(negedge clk);
    if (rst) begin
      in_frame = 0;
      nsamp    = 0;
    end else if (!in_frame) begin
      if (uart_tx === 1'b0) begin
        in_frame = 1;
        samp[0]  = 1'b0;
        busy_all = (busy === 1'b1);
        nsamp    = 1;
      end
    end else begin
      samp[nsamp] = (uart_tx === 1'b1);
      busy_all    = busy_all && (busy === 1'b1);
      nsamp++;
      if (nsamp == FRAME) begin
        automatic bit       ok = 1;
        automatic logic [7:0] data;
        for (int b = 0; b < 10; b++)
          for (int j = 1; j < CPB; j++)
            if (samp[b*CPB+j] != samp[b*CPB]) ok = 0;
        if (samp[0] != 1'b0 || samp[9*CPB] != 1'b1) ok = 0;
        for (int i = 0; i < 8; i++) data[i] = samp[(i+1)*CPB];
        chk("frame_valid", 32'(ok), 32'd1);
        chk("busy_in_frame", 32'(busy_all), 32'd1);
        if (exp_bytes.size() == 0) unexpected("uart_byte", 32'(data));
        else chk("uart_byte", 32'(data), 32'(exp_bytes.pop_front()));
        in_frame = 0;
        nsamp    = 0;
      end
    end
  end

  // Address watcher: each word presents one new address while busy.
  bit            prev_busy = 0;
  logic [AW-1:0] prev_addr = '0;
  initial forever begin
    @(negedge clk);
    if (rst) begin
      prev_busy = 0;
    end else begin
      if (busy === 1'b1 && (!prev_busy || addr_acc !== prev_addr)) begin
        if (exp_addr.size() == 0) unexpected("addr_acc", 32'(addr_acc));
        else chk("addr_acc", 32'(addr_acc), 32'(exp_addr.pop_front()));
      end
      prev_busy = (busy === 1'b1);
      prev_addr = addr_acc;
    end
  end

  // Done watcher: pulse must land on the predicted cycle with busy already low.
  initial forever begin
    @(negedge clk);
    if (!rst && done === 1'b1) begin
      if (exp_done.size() == 0) unexpected("done_cycle", 32'(cyc));
      else begin
        chk("done_cycle", 32'(cyc), 32'(exp_done.pop_front()));
        chk("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end

  task automatic fill_mem();
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
  endtask

  function automatic int latency(input int n);
    return (n == 0) ? 1 : n * (1 + 40 * CPB) + 1;
  endfunction

  task automatic run_dump(input logic [AW-1:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      automatic logic [AW-1:0] a = AW'(int'(b) + i);
      automatic logic [31:0]   w = mem[a];
      exp_addr.push_back(a);
      for (int k = 0; k < 4; k++) exp_bytes.push_back(8'(w >> (8 * k)));
    end
    @(posedge clk);
    #1;
    base_addr = b;
    count     = (AW+1)'(n);
    start     = 1'b1;
    exp_done.push_back(cyc + latency(n));
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int w = 0;
    while (exp_done.size() != 0 && w < budget) begin
      @(posedge clk);
      w++;
    end
    if (exp_done.size() != 0) begin
      unexpected("done_timeout", 32'(w));
      exp_done.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    count     = '0;
    fill_mem();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_uart_tx", 32'(uart_tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_addr_acc", 32'(addr_acc), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single word with a known pattern.
    mem[5] = 32'hDEADBEEF;
    run_dump(6'd5, 1);
    wait_done(latency(1) + 20);

    // Address wrap 62, 63, 0.
    fill_mem();
    run_dump(6'd62, 3);
    wait_done(latency(3) + 20);

    // Empty dump: done only.
    run_dump(6'd17, 0);
    wait_done(20);

    // Second start mid-dump must be ignored.
    fill_mem();
    run_dump(6'd0, 2);
    repeat (100) @(posedge clk);
    #1;
    base_addr = 6'd9;
    count     = 7'd5;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(latency(2) + 20);

    // Reset during data bit 3 of the second byte, together with a competing start.
    fill_mem();
    run_dump(6'd20, 2);
    repeat (1 + 14 * CPB) @(posedge clk);
    #1;
    rst       = 1'b1;
    start     = 1'b1;
    base_addr = 6'd9;
    count     = 7'd3;
    exp_bytes.delete();
    exp_addr.delete();
    exp_done.delete();
    @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("abort_uart_tx", 32'(uart_tx), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    chk("abort_stays_idle", 32'(busy), 32'd0);
    run_dump(6'd20, 2);
    wait_done(latency(2) + 20);

    // Randomized dumps.
    for (int r = 0; r < 4; r++) begin
      automatic int n = $urandom_range(0, 5);
      fill_mem();
      run_dump(AW'($urandom_range(0, 63)), n);
      wait_done(latency(n) + 20);
    end

    // Full array dump.
    fill_mem();
    run_dump(6'd0, 64);
    wait_done(latency(64) + 20);

    repeat (5) @(posedge clk);
    chk("bytes_left", 32'(exp_bytes.size()), 32'd0);
    chk("addr_left", 32'(exp_addr.size()), 32'd0);
    chk("done_left", 32'(exp_done.size()), 32'd0);
    chk("final_uart_idle", 32'(uart_tx), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
